// File: rtl/nes_port_io_if.sv
// CPU-side signal bundle for the $4016/$4017 controller-port block:
// strobe/read pulses, pad and zapper inputs, and the two 5-bit read values.
interface nes_port_io_if;
   logic       strobe_wr;
   logic       strobe_din;
   logic       rd_p1;
   logic       rd_p2;
   logic [7:0] joy1;
   logic [7:0] joy2;
   logic [7:0] joy3;
   logic [7:0] joy4;
   logic       zapper_en;
   logic       light;
   logic       trigger;
   logic [4:0] dout_p1;
   logic [4:0] dout_p2;

   modport master (
      output strobe_wr, strobe_din, rd_p1, rd_p2,
      output joy1, joy2, joy3, joy4,
      output zapper_en, light, trigger,
      input  dout_p1, dout_p2
   );

   modport slave (
      input  strobe_wr, strobe_din, rd_p1, rd_p2,
      input  joy1, joy2, joy3, joy4,
      input  zapper_en, light, trigger,
      output dout_p1, dout_p2
   );
endinterface

// File: rtl/nes_port_io.sv
// $4016/$4017 controller ports: strobe latch, per-port serial shift with read counter,
// zapper merge on port 2. Define FOUR_SCORE_EN for 24-bit four-pad chains with signatures.
module nes_port_io #(
   parameter logic FILL_BIT = 1'b1,
   parameter int   CNT_W    = 5
) (
   input  logic          clk,
   input  logic          reset,
   nes_port_io_if.slave  bus
);

`ifdef FOUR_SCORE_EN
   localparam int REG_W = 24;
`else
   localparam int REG_W = 8;
`endif
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(REG_W);

   logic             strobe_q, strobe_d;
   logic [REG_W-1:0] sr1_q, sr1_d, sr2_q, sr2_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
   logic [REG_W-1:0] pad1_w, pad2_w;
   logic             reload_w, shift1_w, shift2_w;
   logic             d0_p1_w, d0_p2_w;

`ifdef FOUR_SCORE_EN
   assign pad1_w = {8'b0000_1000, bus.joy3, bus.joy1};
   assign pad2_w = {8'b0000_0100, bus.joy4, bus.joy2};
`else
   assign pad1_w = bus.joy1;
   assign pad2_w = bus.joy2;
`endif

   // Reload on every edge while strobed (including the falling write) and on a rising write.
   // Any write cycle suppresses a coincident read shift.
   always_comb begin
      strobe_d = bus.strobe_wr ? bus.strobe_din : strobe_q;
      reload_w = strobe_q | (bus.strobe_wr & bus.strobe_din);
      shift1_w = bus.rd_p1 & ~bus.strobe_wr & ~strobe_q & (cnt1_q != CNT_SAT);
      shift2_w = bus.rd_p2 & ~bus.strobe_wr & ~strobe_q & (cnt2_q != CNT_SAT);

      sr1_d  = sr1_q;
      cnt1_d = cnt1_q;
      sr2_d  = sr2_q;
      cnt2_d = cnt2_q;

      if (reload_w) begin
         sr1_d  = pad1_w;
         cnt1_d = '0;
         sr2_d  = pad2_w;
         cnt2_d = '0;
      end else begin
         if (shift1_w) begin
            sr1_d  = {FILL_BIT, sr1_q[REG_W-1:1]};
            cnt1_d = cnt1_q + CNT_W'(1);
         end
         if (shift2_w) begin
            sr2_d  = {FILL_BIT, sr2_q[REG_W-1:1]};
            cnt2_d = cnt2_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         strobe_q <= 1'b0;
         sr1_q    <= '0;
         sr2_q    <= '0;
         cnt1_q   <= '0;
         cnt2_q   <= '0;
      end else begin
         strobe_q <= strobe_d;
         sr1_q    <= sr1_d;
         sr2_q    <= sr2_d;
         cnt1_q   <= cnt1_d;
         cnt2_q   <= cnt2_d;
      end
   end

   // While strobed, D0 follows live A rather than the registered copy.
   always_comb begin
      d0_p1_w     = strobe_q ? bus.joy1[0] : sr1_q[0];
      d0_p2_w     = strobe_q ? bus.joy2[0] : sr2_q[0];
      bus.dout_p1 = {4'b0000, d0_p1_w};
      if (bus.zapper_en)
         bus.dout_p2 = {bus.trigger, bus.light, 3'b000};
      else
         bus.dout_p2 = {4'b0000, d0_p2_w};
   end

endmodule

// File: tb/tb_nes_port_io.sv
// Randomized and directed bench for nes_port_io against an index-based model of the
// latched pad image (which bit the next read returns), plus fixed-value spot checks.
module tb_nes_port_io;

`ifdef FOUR_SCORE_EN
   localparam int NB = 24;
`else
   localparam int NB = 8;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   nes_port_io_if bus ();

   nes_port_io dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic        m_strobe;
   logic [23:0] m_img1, m_img2;
   int          m_idx1, m_idx2;

   task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [23:0] pad_image(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] sig);
`ifdef FOUR_SCORE_EN
      return {sig, b, a};
`else
      return {16'h0000, a} | 24'(0 & {sig, b});
`endif
   endfunction

   function automatic logic bit_at(input logic [23:0] im, input int idx);
      return (idx < NB) ? im[idx] : 1'b1;
   endfunction

   function automatic logic [4:0] exp_p1();
      return {4'b0000, m_strobe ? bus.joy1[0] : bit_at(m_img1, m_idx1)};
   endfunction

   function automatic logic [4:0] exp_p2();
      if (bus.zapper_en)
         return {bus.trigger, bus.light, 3'b000};
      return {4'b0000, m_strobe ? bus.joy2[0] : bit_at(m_img2, m_idx2)};
   endfunction

   task automatic model_reset();
      m_strobe = 1'b0;
      m_img1   = '0;
      m_img2   = '0;
      m_idx1   = 0;
      m_idx2   = 0;
   endtask

   task automatic model_edge(input logic wr, input logic din, input logic r1, input logic r2);
      if (m_strobe || (wr && din)) begin
         m_img1 = pad_image(bus.joy1, bus.joy3, 8'b0000_1000);
         m_img2 = pad_image(bus.joy2, bus.joy4, 8'b0000_0100);
         m_idx1 = 0;
         m_idx2 = 0;
      end else if (!wr) begin
         if (r1 && m_idx1 < NB) m_idx1++;
         if (r2 && m_idx2 < NB) m_idx2++;
      end
      if (wr) m_strobe = din;
   endtask

   // Called at posedge+1; checks outputs mid-cycle, then advances the model at the edge.
   task automatic drive_cycle(input logic wr, input logic din, input logic r1, input logic r2);
      bus.strobe_wr  = wr;
      bus.strobe_din = din;
      bus.rd_p1      = r1;
      bus.rd_p2      = r2;
      #2;
      check_val("p1", bus.dout_p1, exp_p1());
      check_val("p2", bus.dout_p2, exp_p2());
      @(posedge clk);
      model_edge(wr, din, r1, r2);
      #1;
      bus.strobe_wr  = 1'b0;
      bus.strobe_din = 1'b0;
      bus.rd_p1      = 1'b0;
      bus.rd_p2      = 1'b0;
   endtask

   task automatic latch_pads();
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0] seq;
      logic       wr, din, r1, r2;

      reset          = 1'b1;
      bus.strobe_wr  = 1'b0;
      bus.strobe_din = 1'b0;
      bus.rd_p1      = 1'b0;
      bus.rd_p2      = 1'b0;
      bus.joy1       = 8'h00;
      bus.joy2       = 8'h00;
      bus.joy3       = 8'h00;
      bus.joy4       = 8'h00;
      bus.zapper_en  = 1'b0;
      bus.light      = 1'b1;
      bus.trigger    = 1'b0;
      model_reset();
      #1;
      check_val("rst_p1", bus.dout_p1, 5'b00000);
      check_val("rst_p2", bus.dout_p2, 5'b00000);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Basic latch and shift: A then B..Right, then fill.
      bus.joy1 = 8'h81;
      latch_pads();
      seq = 8'h81;
      for (int i = 0; i < 8; i++) begin
         #1;
         check_val("seq81", bus.dout_p1, {4'b0000, seq[i]});
         drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      end
      for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
`ifndef FOUR_SCORE_EN
      #1;
      check_val("fill", bus.dout_p1, 5'b00001);
`endif

      // Reads while strobed follow live A; fall keeps last reload.
      bus.joy1 = 8'h5A;
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         bus.joy1[0] = ~bus.joy1[0];
         drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      end
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);

      // Zapper on port 2.
      bus.zapper_en = 1'b1;
      bus.light     = 1'b0;
      bus.trigger   = 1'b1;
      bus.joy2      = 8'hFF;
      latch_pads();
      #1;
      check_val("zap_lit", bus.dout_p2, 5'b10000);
      bus.light = 1'b1;
      #1;
      check_val("zap_dark", bus.dout_p2, 5'b11000);
      for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
      bus.zapper_en = 1'b0;
      for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // Strobe write coincident with a read at bit 3; both ports read together.
      bus.joy1 = 8'hB6;
      bus.joy2 = 8'h3C;
      latch_pads();
      for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);
      drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      check_val("coinc_live", bus.dout_p1, {4'b0000, bus.joy1[0]});
      drive_cycle(1'b1, 1'b0, 1'b1, 1'b1);
      drive_cycle(1'b1, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);

      // Asynchronous reset between edges mid-sequence.
      bus.joy1 = 8'hFF;
      latch_pads();
      for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      #3;
      reset = 1'b1;
      model_reset();
      #1;
      check_val("arst_p1", bus.dout_p1, 5'b00000);
      check_val("arst_p2", bus.dout_p2, exp_p2());
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);

`ifdef FOUR_SCORE_EN
      bus.joy1 = 8'h01;
      bus.joy3 = 8'h02;
      bus.joy2 = 8'h00;
      bus.joy4 = 8'h00;
      latch_pads();
      for (int i = 0; i < 27; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);
`endif

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0) bus.joy1 = 8'($urandom);
         if ($urandom_range(0, 7) == 0) bus.joy2 = 8'($urandom);
         if ($urandom_range(0, 7) == 0) bus.joy3 = 8'($urandom);
         if ($urandom_range(0, 7) == 0) bus.joy4 = 8'($urandom);
         if ($urandom_range(0, 31) == 0) bus.zapper_en = 1'($urandom);
         bus.light   = 1'($urandom);
         bus.trigger = 1'($urandom);
         wr  = ($urandom_range(0, 11) == 0);
         din = 1'($urandom);
         r1  = ($urandom_range(0, 2) == 0);
         r2  = ($urandom_range(0, 2) == 0);
         drive_cycle(wr, din, r1, r2);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
